// File: rtl/mem_access_unit_if.sv
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Request/response handshake plus data-memory port bundle for
//                the load/store memory access unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
  parameter int ADDR_W = 5
);
  // Upstream request channel
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  // Downstream response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  // Data-memory port (combinational read, synchronous write)
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // The access unit itself
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  // The surrounding environment: requester, response sink and data memory
  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : Single-outstanding load/store unit in front of a 32-bit
//                word-addressed data memory. Handles sign/zero-extended sub-word
//                loads and read-modify-write sub-word stores, and flags
//                misaligned or out-of-range accesses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  wire logic          clk,
  input  wire logic          clrn,
  mem_access_unit_if.slave   bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic [1:0]        lane_q;       // byte lane within the word, addr[1:0]
  logic [15:0]       wdata_q;      // sub-word store data (SH/SB)
  logic [31:0]       word_q;       // captured memory word, or full SW data
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              req_err;
  logic [31:0]       load_data_d;
  logic [31:0]       wr_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  // Decode misalignment / out-of-range for the request currently offered
  always_comb begin
    req_err = |bus.req_addr[31:ADDR_W+2];
    case (bus.req_op)
      OP_LW, OP_SW:         req_err = req_err | (bus.req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: req_err = req_err | bus.req_addr[0];
      default:              req_err = req_err;
    endcase
  end

  // Extract and extend the addressed lane of the word coming back from memory
  always_comb begin
    rd_byte     = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half     = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_data_d = 32'd0;
    case (op_q)
      OP_LW:   load_data_d = bus.mem_rdata;
      OP_LH:   load_data_d = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data_d = {16'd0, rd_half};
      OP_LB:   load_data_d = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data_d = {24'd0, rd_byte};
      default: load_data_d = 32'd0;
    endcase
  end

  // Merge sub-word store data into the captured word; SW passes through as-is
  always_comb begin
    wr_word = word_q;
    case (op_q)
      OP_SH: begin
        if (lane_q[1]) wr_word[31:16] = wdata_q;
        else           wr_word[15:0]  = wdata_q;
      end
      OP_SB:   wr_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      default: wr_word = word_q;
    endcase
  end

  // Access sequencer with registered handshake and memory-control outputs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LW;
      lane_q      <= 2'd0;
      wdata_q     <= 16'd0;
      word_q      <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            lane_q      <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata[15:0];
            mem_addr_q  <= bus.req_addr[ADDR_W+1:2];
            req_ready_q <= 1'b0;
            if (req_err) begin
              // Faulting accesses never touch memory
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
              state_q     <= S_RESP;
            end else if (bus.req_op == OP_SW) begin
              word_q   <= bus.req_wdata;
              mem_we_q <= 1'b1;
              state_q  <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end

        S_READ: begin
          word_q <= bus.mem_rdata;
          if (op_q == OP_SH || op_q == OP_SB) begin
            mem_we_q <= 1'b1;
            state_q  <= S_WRITE;
          end else begin
            rsp_rdata_q <= load_data_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end

        S_WRITE: begin
          mem_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
          state_q     <= S_RESP;
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  // Write data only leaves the unit while the write strobe is up
  assign bus.mem_wdata = mem_we_q ? wr_word : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit with a
//                32-word behavioural data memory.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic clk;
  logic clrn;
  int   n_total;
  int   n_bad;
  int   we_cnt;
  logic [4:0]  last_waddr;
  logic [31:0] last_wdata;
  logic [31:0] mem [32];

  mem_access_unit_if #(.ADDR_W(5)) bus ();

  mem_access_unit #(.ADDR_W(5)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      last_waddr        <= bus.mem_addr;
      last_wdata        <= bus.mem_wdata;
      we_cnt            <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one request with rsp_ready held high and check the full transaction
  task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input int exp_we);
    int lat;
    int we0;
    @(negedge clk);
    we0           = we_cnt;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = ~op;
    bus.req_addr  = 32'hFFFF_FFFF;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
    chk({tag, "_idle_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_idle_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_we_pulses"}, we_cnt - we0, exp_we);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we0;
    int n;
    n_total = 0;
    n_bad   = 0;
    we_cnt  = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[2] = 32'h1122_3344;
    mem[3] = 32'h0000_0003;
    mem[4] = 32'h4444_4444;
    mem[5] = 32'h0000_80F5;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    clrn = 1'b0;

    // Reset state
    #12;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr",  {27'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    #2 clrn = 1'b1;

    // Loads
    do_req("lw_0c",  3'b000, 32'h0C, 32'h0, 32'h0000_0003, 1'b0, 2, 0);
    do_req("lb_14",  3'b011, 32'h14, 32'h0, 32'hFFFF_FFF5, 1'b0, 2, 0);
    do_req("lbu_14", 3'b100, 32'h14, 32'h0, 32'h0000_00F5, 1'b0, 2, 0);
    do_req("lh_14",  3'b001, 32'h14, 32'h0, 32'hFFFF_80F5, 1'b0, 2, 0);
    do_req("lhu_14", 3'b010, 32'h14, 32'h0, 32'h0000_80F5, 1'b0, 2, 0);
    do_req("lb_15",  3'b011, 32'h15, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);
    do_req("lh_16",  3'b001, 32'h16, 32'h0, 32'h0000_0000, 1'b0, 2, 0);

    // Stores
    do_req("sb_09", 3'b111, 32'h09, 32'h0000_00AB, 32'h0, 1'b0, 3, 1);
    chk("sb_09_waddr", {27'd0, last_waddr}, 32'd2);
    chk("sb_09_wdata", last_wdata, 32'h1122_AB44);
    chk("sb_09_mem",   mem[2], 32'h1122_AB44);
    do_req("sh_0a", 3'b110, 32'h0A, 32'hFFFF_5566, 32'h0, 1'b0, 3, 1);
    chk("sh_0a_mem", mem[2], 32'h5566_AB44);
    do_req("sw_1c", 3'b101, 32'h1C, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1);
    chk("sw_1c_mem", mem[7], 32'hCAFE_F00D);
    chk("sw_1c_waddr", {27'd0, last_waddr}, 32'd7);

    // Faulting accesses
    do_req("lw_06_err", 3'b000, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("sw_80_err", 3'b101, 32'h80, 32'h1234_5678, 32'h0, 1'b1, 1, 0);
    do_req("sh_03_err", 3'b110, 32'h03, 32'h0000_1234, 32'h0, 1'b1, 1, 0);
    chk("err_mem0_untouched", mem[0], 32'h0);

    // Response back-pressure, with a competing request held on the input
    @(negedge clk);
    we0 = we_cnt;
    bus.req_op    = 3'b010;
    bus.req_addr  = 32'h14;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_op    = 3'b111;
    bus.req_addr  = 32'h0C;
    bus.req_wdata = 32'h0000_00EE;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", {31'd0, bus.rsp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_hold_rdata", bus.rsp_rdata, 32'h0000_80F5);
      chk("bp_hold_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("bp_no_write", we_cnt - we0, 32'd0);
    chk("bp_mem3_kept", mem[3], 32'h0000_0003);

    // Reset asserted while the SW write strobe is up
    @(negedge clk);
    we0 = we_cnt;
    bus.req_op    = 3'b101;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rw_we_up", {31'd0, bus.mem_we}, 32'd1);
    #1 clrn = 1'b0;
    #1;
    chk("rw_we_drop",   {31'd0, bus.mem_we}, 32'd0);
    chk("rw_wdata",     bus.mem_wdata, 32'd0);
    chk("rw_addr",      {27'd0, bus.mem_addr}, 32'd0);
    chk("rw_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rw_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rw_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    @(posedge clk);
    #2 clrn = 1'b1;
    chk("rw_mem4_kept", mem[4], 32'h4444_4444);
    chk("rw_no_write", we_cnt - we0, 32'd0);
    // First edge after reset release must already accept
    do_req("post_rst_lw", 3'b000, 32'h0C, 32'h0, 32'h0000_0003, 1'b0, 2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, word-address width driven to the data memory (32 words).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  upstream request present.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data; SH uses [15:0], SB uses [7:0].
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  downstream takes response.
REQ-011 SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  misaligned or out-of-range access.
REQ-013 SHALL have port mem_we  output  1  data-memory write enable.
REQ-014 SHALL have port mem_addr  output  ADDR_W  data-memory word address.
REQ-015 SHALL have port mem_wdata  output  32  data-memory write data.
REQ-016 SHALL have port mem_rdata  input  32  data-memory combinational read data for mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with req_valid & req_ready, latching op, addr, wdata.
REQ-019 SHALL flag error when addr[31:ADDR_W+2] != 0, or LW/SW with addr[1:0] != 0, or LH/LHU/SH with addr[0] != 0; error: IDLE -> RESP, rsp_err = 1, mem_we never asserted.
REQ-020 SHALL sequence loads IDLE -> READ -> RESP, SW IDLE -> WRITE -> RESP, SH/SB IDLE -> READ -> WRITE -> RESP.
REQ-021 SHALL drive mem_addr = latched addr[ADDR_W+1:2] in READ, WRITE, RESP; 0 in IDLE.
REQ-022 SHALL in READ capture mem_rdata into an internal word register at the clock edge leaving READ.
REQ-023 SHALL use little-endian lanes: byte k = bits [8k+7:8k], halfword h = bits [16h+15:16h], lane from addr[1:0].
REQ-024 SHALL for loads form rsp_rdata: LW whole word; LH/LB sign-extend; LHU/LBU zero-extend; registered on entry to RESP.
REQ-025 SHALL for SH/SB merge the new halfword/byte into the captured word, other lanes unchanged; SW writes req_wdata unmodified.
REQ-026 SHALL assert mem_we for exactly one cycle, in WRITE only, with mem_wdata holding the final word; mem_wdata = 0 outside WRITE.
REQ-027 SHALL hold rsp_valid = 1 and rsp_rdata/rsp_err stable throughout RESP; RESP -> IDLE on rsp_ready; no new request accepted in the same cycle.
REQ-028 SHALL give latency accept-to-rsp_valid of 1 cycle (error), 2 cycles (loads, SW), 3 cycles (SH, SB).
REQ-029 SHALL ignore req_* inputs in all states other than IDLE.
REQ-030 SHALL clear rsp_rdata and rsp_err to 0 on RESP -> IDLE.

Reset
REQ-031 SHALL on clrn = 0 immediately force state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_we 0, mem_addr 0, mem_wdata 0, req_ready 1.
REQ-032 SHALL, if clrn falls while in WRITE before the clock edge, drop mem_we asynchronously so no write commits; the in-flight request is discarded, no response.
REQ-033 SHALL accept a request on the first rising edge after clrn returns high.

Verification
REQ-034 SHALL cover: word 3 = 0x00000003, LW addr 0x0C, rsp_ready = 1 -> rsp_valid 2 cycles after accept, rsp_rdata 0x00000003, rsp_err 0.
REQ-035 SHALL cover: word 5 = 0x000080F5, LB addr 0x14 -> 0xFFFFFFF5; LBU -> 0x000000F5; LH -> 0xFFFF80F5; LHU -> 0x000080F5.
REQ-036 SHALL cover: word 2 = 0x11223344, SB addr 0x09 wdata 0xAB -> one mem_we pulse, mem_addr 2, mem_wdata 0x1122AB44, rsp 3 cycles after accept.
REQ-037 SHALL cover: LW addr 0x06 and SW addr 0x80 -> rsp_err 1 one cycle after accept, rsp_rdata 0, no mem_we.
REQ-038 SHALL cover: rsp_ready held 0 for 4 cycles -> rsp_valid/rsp_rdata stable, req_ready 0; rsp_ready 1 -> IDLE next cycle.
REQ-039 SHALL cover: SW addr 0x10 wdata 0xDEADBEEF, clrn pulsed low during WRITE -> memory word 4 unchanged, all outputs at reset values.
